rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//   Owns the single register-file write port (addr/data/enable) and shares it between
//   two writeback requesters: A = ALU writeback, B = load writeback.
//   Fair round-robin arbitration with valid/ready handshakes; registered 1-cycle write issue.
//   $zero write suppression; clear sequencer that sweeps every register to 0 on command.
//   Sits between the execute/memory stages and the register file write port.
// PARAMETERS
//   AW            5   register address width; the register file holds 2**AW entries
//   DW            32  data width
//   ZERO_PROTECT  1   1: requester writes to address 0 complete the handshake but never raise wr_en
// PORTS
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous reset, active low
//   a_valid      in   1   requester A has a write pending
//   a_addr       in   AW  requester A destination register
//   a_data       in   DW  requester A write data
//   a_ready      out  1   requester A accepted this cycle (transfer = a_valid & a_ready)
//   b_valid      in   1   requester B has a write pending
//   b_addr       in   AW  requester B destination register
//   b_data       in   DW  requester B write data
//   b_ready      out  1   requester B accepted this cycle
//   clear_start  in   1   1-cycle pulse: start the zero sweep of all registers
//   clear_busy   out  1   sweep in progress
//   clear_done   out  1   1-cycle pulse after the last sweep write issues
//   wr_en        out  1   to register file write enable (registered)
//   wr_addr      out  AW  to register file write address (registered)
//   wr_data      out  DW  to register file write data (registered)
// BEHAVIOUR
//   Reset values (async, rst_n=0):
//     state=IDLE, prio=A; wr_en=0, wr_addr=0, wr_data=0; clear_busy=0, clear_done=0, cnt=0.
//   FSM states: IDLE and CLEAR.
//     IDLE -> CLEAR on clear_start=1.
//     CLEAR -> IDLE after the write to address 2**AW-1 issues.
//   IDLE arbitration (combinational ready, from valids and prio):
//     a_ready = ~clear_start & a_valid & (~b_valid | prio==A).
//     b_ready = ~clear_start & b_valid & (~a_valid | prio==B).
//     At most one ready per cycle; ready is never asserted without the matching valid.
//   prio updates only on a transfer: it moves to the requester that did NOT win.
//   A single valid requester wins regardless of prio.
//   Write issue latency:
//     A transfer in cycle N drives wr_en/wr_addr/wr_data in cycle N+1, for exactly one cycle.
//     wr_en=0 in any cycle that follows a cycle with no transfer.
//   Zero protect (ZERO_PROTECT=1):
//     A transfer with addr==0 still raises ready, but wr_en=0 in cycle N+1.
//     wr_addr/wr_data still update. prio still rotates.
//   Clear sweep:
//     clear_start in cycle N blocks both readies in cycle N, enters CLEAR, sets clear_busy
//     from N+1 and loads cnt=0.
//     Each CLEAR cycle issues wr_en=1, wr_addr=cnt, wr_data=0 (on the next edge), then cnt++.
//     Address 0 is included. ZERO_PROTECT does not apply to sweep writes.
//     Sweep = 2**AW consecutive wr_en cycles with no gaps.
//     clear_done pulses in the cycle the last write (addr 2**AW-1) is on the port.
//     clear_busy falls in that same cycle; readies are allowed again in that cycle.
//     In CLEAR: a_ready=b_ready=0, and valid requesters hold their requests.
//     clear_start during CLEAR is ignored; it does not restart the sweep.
//   Counter cnt is AW+1 bits wide. The sweep ends on the terminal count, not on wrap.
//   Reset mid-sweep: the sweep aborts and all outputs return to reset values. No resume.
//   Handshake rule: requester inputs are sampled only in the transfer cycle.
//     Changing addr/data while valid=1 and ready=0 is legal; the last value is used.
// TESTING
//   1. Reset, then A only: valid=1, addr=5, data=0x1234 for 1 cycle
//      -> a_ready=1 that cycle; next cycle wr_en=1, wr_addr=5, wr_data=0x1234; then wr_en=0.
//   2. A and B valid together for 4 cycles (A addr=1, B addr=2)
//      -> grants A,B,A,B; wr_addr on the port 1,2,1,2; prio=A after reset.
//   3. B writes addr=0, data=0xFFFF_FFFF with ZERO_PROTECT=1
//      -> b_ready=1 and prio rotates; wr_en stays 0.
//   4. clear_start with A valid in the same cycle
//      -> a_ready=0; 32 consecutive wr_en cycles, addr 0..31, data 0; clear_done on addr 31;
//      -> A accepted in the first IDLE cycle.
//   5. clear_start pulsed again at sweep addr 10
//      -> ignored: the sweep continues 11..31, total 32 writes.
//   6. rst_n low at sweep addr 17
//      -> wr_en=0 and clear_busy=0 immediately (async); after release the state is IDLE
//      -> no further sweep writes.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Register-file write-port owner: round-robin arbitration between ALU (A) and load (B)
// writeback, with $zero write suppression and a full-file zero sweep on command.
module rf_write_arbiter #(
    parameter int unsigned AW           = 5,
    parameter int unsigned DW           = 32,
    parameter bit          ZERO_PROTECT = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    input  logic          clear_start,
    output logic          clear_busy,
    output logic          clear_done,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    localparam logic [AW:0] LastCnt = {1'b0, {AW{1'b1}}};

    state_e      state_q;
    logic        prio_q;  // 0: A has priority, 1: B has priority
    logic [AW:0] cnt_q;
    logic        is_idle;

    always_comb begin
        is_idle = (state_q == StIdle);
        a_ready = is_idle & ~clear_start & a_valid & (~b_valid | ~prio_q);
        b_ready = is_idle & ~clear_start & b_valid & (~a_valid | prio_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            prio_q     <= 1'b0;
            cnt_q      <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    clear_done <= 1'b0;
                    if (a_ready) begin
                        wr_en   <= ~(ZERO_PROTECT && (a_addr == '0));
                        wr_addr <= a_addr;
                        wr_data <= a_data;
                        prio_q  <= 1'b1;
                    end else if (b_ready) begin
                        wr_en   <= ~(ZERO_PROTECT && (b_addr == '0));
                        wr_addr <= b_addr;
                        wr_data <= b_data;
                        prio_q  <= 1'b0;
                    end else begin
                        wr_en <= 1'b0;
                    end
                    if (clear_start) begin
                        state_q    <= StClear;
                        clear_busy <= 1'b1;
                        cnt_q      <= '0;
                    end
                end
                StClear: begin
                    // Sweep writes bypass zero protection so address 0 is cleared too.
                    wr_en   <= 1'b1;
                    wr_addr <= cnt_q[AW-1:0];
                    wr_data <= '0;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_q    <= StIdle;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        clear_done <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: cycle-stamped write scoreboard plus per-task
// handshake checks against a small arbitration model.
module tb_rf_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NREG = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_data = '0;
    logic          a_ready;
    logic          b_valid = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_data = '0;
    logic          b_ready;
    logic          clear_start = 1'b0;
    logic          clear_busy;
    logic          clear_done;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    rf_write_arbiter #(.AW(AW), .DW(DW), .ZERO_PROTECT(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t  wr_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic m_prio = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor: every wr_en cycle must match the head entry stamped for this cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
                wr_t e;
                e = wr_q.pop_front();
                checks++;
                if (wr_en !== 1'b1 || wr_addr !== e.addr || wr_data !== e.data) begin
                    errors++;
                    $display("FAIL write_port cyc=%0d got en=%b addr=%0d data=%h want en=1 addr=%0d data=%h",
                             cyc, wr_en, wr_addr, wr_data, e.addr, e.data);
                end
            end else if (wr_en !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write cyc=%0d got en=%b addr=%0d want en=0",
                         cyc, wr_en, wr_addr);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle-state arbitration model; queues the write a transfer should produce.
    task automatic arb_model(output logic ea, output logic eb);
        ea = !clear_start && a_valid && (!b_valid || !m_prio);
        eb = !clear_start && b_valid && (!a_valid || m_prio);
        if (ea) begin
            if (a_addr != 0) wr_q.push_back('{cyc + 1, a_addr, a_data});
            m_prio = 1'b1;
        end else if (eb) begin
            if (b_addr != 0) wr_q.push_back('{cyc + 1, b_addr, b_data});
            m_prio = 1'b0;
        end
    endtask

    task automatic push_sweep(input int start_cyc);
        for (int i = 0; i < NREG; i++) wr_q.push_back('{start_cyc + 2 + i, AW'(i), '0});
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        wr_q.delete();
        m_prio = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || clear_busy !== 1'b0 ||
            clear_done !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got en=%b addr=%0d data=%h busy=%b done=%b ra=%b rb=%b want all 0",
                     wr_en, wr_addr, wr_data, clear_busy, clear_done, a_ready, b_ready);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_single_a();
        logic ea, eb;
        a_valid = 1'b1; a_addr = 5; a_data = 32'h1234;
        @(negedge clk);
        arb_model(ea, eb);
        checks++;
        if (a_ready !== ea || b_ready !== eb) begin
            errors++;
            $display("FAIL single_a_ready got a=%b b=%b want a=%b b=%b", a_ready, b_ready, ea, eb);
        end
        step();
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_a_idle got a_ready=%b want 0", a_ready);
        end
        step();
        step();
    endtask

    task automatic test_round_robin();
        logic ea, eb;
        logic [3:0] want = 4'b1010;  // 1 = A granted, per cycle from first
        apply_reset();
        a_valid = 1'b1; a_addr = 1; a_data = 32'hA0;
        b_valid = 1'b1; b_addr = 2; b_data = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            a_data = 32'hA0 + i;
            b_data = 32'hB0 + i;
            @(negedge clk);
            arb_model(ea, eb);
            checks++;
            if (a_ready !== want[3-i] || b_ready !== ~want[3-i] || ea !== want[3-i]) begin
                errors++;
                $display("FAIL round_robin_%0d got a=%b b=%b want a=%b b=%b",
                         i, a_ready, b_ready, want[3-i], ~want[3-i]);
            end
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
    endtask

    task automatic test_zero_protect();
        logic ea, eb;
        a_valid = 1'b1; a_addr = 9; a_data = 32'h99;
        @(negedge clk);
        arb_model(ea, eb);
        step();
        a_valid = 1'b0;
        b_valid = 1'b1; b_addr = 0; b_data = 32'hFFFF_FFFF;
        @(negedge clk);
        arb_model(ea, eb);
        checks++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_protect_ready got a=%b b=%b want a=0 b=1", a_ready, b_ready);
        end
        step();
        // B just won, so A must win a contended cycle next.
        a_valid = 1'b1; a_addr = 4; a_data = 32'h44;
        b_addr = 6; b_data = 32'h66;
        @(negedge clk);
        arb_model(ea, eb);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_protect_prio got a=%b b=%b want a=1 b=0", a_ready, b_ready);
        end
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        step();
    endtask

    // Runs one sweep; restart_at > 0 pulses clear_start again at that sweep cycle offset.
    task automatic run_sweep(input bit use_b, input int restart_at, input string tag);
        logic ea, eb;
        int k;
        if (use_b) begin
            b_valid = 1'b1; b_addr = 3; b_data = 32'h3333;
        end else begin
            a_valid = 1'b1; a_addr = 7; a_data = 32'hAA;
        end
        clear_start = 1'b1;
        @(negedge clk);
        k = cyc;
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_start_block got a=%b b=%b want 0 0", tag, a_ready, b_ready);
        end
        push_sweep(k);
        step();
        clear_start = 1'b0;
        for (int i = 1; i <= NREG; i++) begin
            clear_start = (i == restart_at);
            @(negedge clk);
            checks++;
            if (clear_busy !== 1'b1 || clear_done !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy_%0d got busy=%b done=%b a=%b b=%b want 1 0 0 0",
                         tag, i, clear_busy, clear_done, a_ready, b_ready);
            end
            step();
        end
        clear_start = 1'b0;
        @(negedge clk);
        arb_model(ea, eb);
        checks++;
        if (clear_done !== 1'b1 || clear_busy !== 1'b0 || a_ready !== ea || b_ready !== eb ||
            (ea | eb) !== 1'b1) begin
            errors++;
            $display("FAIL %s_done got done=%b busy=%b a=%b b=%b want 1 0 %b %b",
                     tag, clear_done, clear_busy, a_ready, b_ready, ea, eb);
        end
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (clear_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse got done=%b want 0", tag, clear_done);
        end
        step();
        step();
    endtask

    task automatic test_reset_mid_sweep();
        clear_start = 1'b1;
        @(negedge clk);
        push_sweep(cyc);
        step();
        clear_start = 1'b0;
        for (int i = 1; i < 19; i++) step();
        @(negedge clk);  // sweep address 17 on the port now
        #1 rst_n = 1'b0;
        wr_q.delete();
        m_prio = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b0 || clear_busy !== 1'b0 || clear_done !== 1'b0 ||
            wr_addr !== '0 || wr_data !== '0) begin
            errors++;
            $display("FAIL reset_mid_sweep got en=%b busy=%b done=%b addr=%0d want 0 0 0 0",
                     wr_en, clear_busy, clear_done, wr_addr);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (clear_busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_busy_%0d got %b want 0", i, clear_busy);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_round_robin();
        test_zero_protect();
        run_sweep(1'b0, 0, "clear");
        run_sweep(1'b1, 12, "restart");
        test_reset_mid_sweep();
        step();
        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", wr_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
